// File: rtl/inst_buffer_pkg.sv
// Shared definitions for the fetch-to-decode instruction buffer: exception
// cause codes, default depth and the per-entry storage layout.
package inst_buffer_pkg;

   localparam int unsigned CAUSE_W = 7;

   localparam logic [CAUSE_W-1:0] EXCEPTION_ADEF = 7'h08;
   localparam logic [CAUSE_W-1:0] EXCEPTION_INE  = 7'h0d;

   localparam int unsigned IB_DEPTH_DEFAULT = 8;

   typedef struct packed {
      logic [31:0]        pc;
      logic [31:0]        inst;
      logic               fetch_exc;
      logic [CAUSE_W-1:0] fetch_cause;
      logic               buf_exc;
      logic [CAUSE_W-1:0] buf_cause;
   } ib_entry_t;

   // Misaligned PCs raise a buffer-side address fault; unused causes read as INE.
   function automatic ib_entry_t ib_make_entry(input logic [31:0]        pc,
                                               input logic [31:0]        inst,
                                               input logic               fetch_exc,
                                               input logic [CAUSE_W-1:0] fetch_cause);
      ib_entry_t e;
      e.pc          = pc;
      e.inst        = inst;
      e.fetch_exc   = fetch_exc;
      e.fetch_cause = fetch_exc ? fetch_cause : EXCEPTION_INE;
      e.buf_exc     = (pc[1:0] != 2'b00);
      e.buf_cause   = (pc[1:0] != 2'b00) ? EXCEPTION_ADEF : EXCEPTION_INE;
      return e;
   endfunction

endpackage

// File: rtl/inst_buffer.sv
// Circular instruction FIFO between fetch and decode with flush support and
// one-cycle push-to-visible latency.
module inst_buffer
   import inst_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = IB_DEPTH_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   fetch_valid,
   output logic                   fetch_ready,
   input  logic [31:0]            fetch_pc,
   input  logic [31:0]            fetch_inst,
   input  logic                   fetch_exception,
   input  logic [CAUSE_W-1:0]     fetch_exception_cause,
   output logic                   dec_valid,
   input  logic                   dec_ready,
   output logic [31:0]            dec_pc,
   output logic [31:0]            dec_inst,
   output logic [2:0]             dec_is_exception,
   output logic [CAUSE_W-1:0]     dec_pc_exception_cause,
   output logic [CAUSE_W-1:0]     dec_instbuffer_exception_cause,
   output logic [$clog2(DEPTH):0] occupancy
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   ib_entry_t r_mem [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;

   logic      w_push;
   logic      w_pop;
   ib_entry_t w_new_entry;
   ib_entry_t w_head_entry;

   assign fetch_ready = (r_count != FULL_COUNT) && rst_n && !flush;
   assign dec_valid   = (r_count != '0) && rst_n && !flush;
   assign w_push      = fetch_valid && fetch_ready;
   assign w_pop       = dec_valid && dec_ready;
   assign occupancy   = r_count;

   assign w_new_entry  = ib_make_entry(fetch_pc, fetch_inst, fetch_exception,
                                       fetch_exception_cause);
   assign w_head_entry = r_mem[r_head];

   // Reset outranks flush, flush outranks any handshake in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + 1'b1;
         end
         if (w_pop) begin
            r_head <= r_head + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_tail] <= w_new_entry;
      end
   end

   always_comb begin
      dec_pc                         = '0;
      dec_inst                       = '0;
      dec_is_exception               = '0;
      dec_pc_exception_cause         = EXCEPTION_INE;
      dec_instbuffer_exception_cause = EXCEPTION_INE;
      if (dec_valid) begin
         dec_pc                         = w_head_entry.pc;
         dec_inst                       = w_head_entry.inst;
         dec_is_exception               = {w_head_entry.fetch_exc, w_head_entry.buf_exc, 1'b0};
         dec_pc_exception_cause         = w_head_entry.fetch_cause;
         dec_instbuffer_exception_cause = w_head_entry.buf_cause;
      end
   end

endmodule

// File: tb/tb_inst_buffer.sv
// Directed self-checking bench for inst_buffer at the default depth of 8.
module tb_inst_buffer;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_inst;
   logic        fetch_exception;
   logic [6:0]  fetch_exception_cause;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_pc;
   logic [31:0] dec_inst;
   logic [2:0]  dec_is_exception;
   logic [6:0]  dec_pc_exception_cause;
   logic [6:0]  dec_instbuffer_exception_cause;
   logic [3:0]  occupancy;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [31:0] ADEF = 32'h08;
   localparam logic [31:0] INE  = 32'h0d;

   inst_buffer #(.DEPTH(8)) dut (
      .clk                            (clk),
      .rst_n                          (rst_n),
      .flush                          (flush),
      .fetch_valid                    (fetch_valid),
      .fetch_ready                    (fetch_ready),
      .fetch_pc                       (fetch_pc),
      .fetch_inst                     (fetch_inst),
      .fetch_exception                (fetch_exception),
      .fetch_exception_cause          (fetch_exception_cause),
      .dec_valid                      (dec_valid),
      .dec_ready                      (dec_ready),
      .dec_pc                         (dec_pc),
      .dec_inst                       (dec_inst),
      .dec_is_exception               (dec_is_exception),
      .dec_pc_exception_cause         (dec_pc_exception_cause),
      .dec_instbuffer_exception_cause (dec_instbuffer_exception_cause),
      .occupancy                      (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive_push(input logic [31:0] pc, input logic [31:0] inst,
                             input logic fexc, input logic [6:0] fcause);
      fetch_valid           = 1'b1;
      fetch_pc              = pc;
      fetch_inst            = inst;
      fetch_exception       = fexc;
      fetch_exception_cause = fcause;
   endtask

   task automatic pop_one();
      dec_ready = 1'b1;
      tick();
      dec_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b0;
      fetch_pc = '0; fetch_inst = '0; fetch_exception = 1'b0; fetch_exception_cause = '0;

      // Reset state
      tick(); tick();
      settle();
      chk("rst_fetch_ready", 32'(fetch_ready), 32'd0);
      chk("rst_dec_valid", 32'(dec_valid), 32'd0);
      chk("rst_occupancy", 32'(occupancy), 32'd0);
      rst_n = 1'b1;
      settle();
      chk("post_rst_fetch_ready", 32'(fetch_ready), 32'd1);

      // Single push, one-cycle latency, no bypass
      drive_push(32'h1c000000, 32'h58000c85, 1'b0, 7'h00);
      settle();
      chk("no_bypass_dec_valid", 32'(dec_valid), 32'd0);
      tick();
      fetch_valid = 1'b0;
      settle();
      chk("first_dec_valid", 32'(dec_valid), 32'd1);
      chk("first_dec_pc", dec_pc, 32'h1c000000);
      chk("first_dec_inst", dec_inst, 32'h58000c85);
      chk("first_dec_exc", 32'(dec_is_exception), 32'd0);
      chk("first_pc_cause", 32'(dec_pc_exception_cause), INE);
      chk("first_buf_cause", 32'(dec_instbuffer_exception_cause), INE);
      pop_one();
      settle();
      chk("first_pop_occ", 32'(occupancy), 32'd0);
      chk("first_pop_valid", 32'(dec_valid), 32'd0);
      chk("idle_dec_pc_zero", dec_pc, 32'd0);

      // Fill to full, then drain in order
      for (int i = 0; i < 8; i++) begin
         drive_push(32'h1000 + 32'(4 * i), 32'hA000 + 32'(i), 1'b0, 7'h00);
         tick();
      end
      fetch_valid = 1'b0;
      settle();
      chk("full_occ", 32'(occupancy), 32'd8);
      chk("full_fetch_ready", 32'(fetch_ready), 32'd0);
      for (int i = 0; i < 8; i++) begin
         dec_ready = 1'b1;
         if (i == 0) drive_push(32'hdead0000, 32'h0, 1'b0, 7'h00);
         settle();
         if (i == 0) chk("full_pop_no_push", 32'(fetch_ready), 32'd0);
         chk("drain_pc", dec_pc, 32'h1000 + 32'(4 * i));
         tick();
         fetch_valid = 1'b0;
      end
      dec_ready = 1'b0;
      settle();
      chk("drained_valid", 32'(dec_valid), 32'd0);
      chk("drained_occ", 32'(occupancy), 32'd0);

      // Continuous push+pop across pointer wrap
      drive_push(32'h2000, 32'h0, 1'b0, 7'h00);
      tick();
      for (int k = 0; k < 20; k++) begin
         drive_push(32'h2000 + 32'(4 * (k + 1)), 32'h0, 1'b0, 7'h00);
         dec_ready = 1'b1;
         settle();
         chk("stream_pc", dec_pc, 32'h2000 + 32'(4 * k));
         chk("stream_occ", 32'(occupancy), 32'd1);
         tick();
      end
      fetch_valid = 1'b0;
      settle();
      chk("stream_last_pc", dec_pc, 32'h2000 + 32'(4 * 20));
      tick();
      dec_ready = 1'b0;
      settle();
      chk("stream_empty", 32'(dec_valid), 32'd0);

      // Exception fields
      drive_push(32'h1c000002, 32'h0, 1'b0, 7'h00);
      tick();
      fetch_valid = 1'b0;
      settle();
      chk("adef_flags", 32'(dec_is_exception), 32'h2);
      chk("adef_buf_cause", 32'(dec_instbuffer_exception_cause), ADEF);
      chk("adef_pc_cause", 32'(dec_pc_exception_cause), INE);
      pop_one();
      drive_push(32'h1c000004, 32'h0, 1'b1, 7'h08);
      tick();
      fetch_valid = 1'b0;
      settle();
      chk("fexc_flags", 32'(dec_is_exception), 32'h4);
      chk("fexc_pc_cause", 32'(dec_pc_exception_cause), 32'h08);
      chk("fexc_buf_cause", 32'(dec_instbuffer_exception_cause), INE);
      pop_one();
      drive_push(32'h1c000008, 32'h0, 1'b0, 7'h55);
      tick();
      fetch_valid = 1'b0;
      settle();
      chk("nofexc_pc_cause", 32'(dec_pc_exception_cause), INE);
      pop_one();

      // Flush with 5 held and a concurrent push
      for (int i = 0; i < 5; i++) begin
         drive_push(32'h3000 + 32'(4 * i), 32'h0, 1'b0, 7'h00);
         tick();
      end
      fetch_valid = 1'b0;
      settle();
      chk("preflush_occ", 32'(occupancy), 32'd5);
      flush = 1'b1;
      dec_ready = 1'b1;
      drive_push(32'hbad00000, 32'h0, 1'b0, 7'h00);
      settle();
      chk("flush_fetch_ready", 32'(fetch_ready), 32'd0);
      chk("flush_dec_valid", 32'(dec_valid), 32'd0);
      tick();
      flush = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b0;
      settle();
      chk("postflush_occ", 32'(occupancy), 32'd0);
      chk("postflush_valid", 32'(dec_valid), 32'd0);
      drive_push(32'h4000, 32'h0, 1'b0, 7'h00);
      tick();
      fetch_valid = 1'b0;
      settle();
      chk("postflush_pc", dec_pc, 32'h4000);
      chk("postflush_occ1", 32'(occupancy), 32'd1);
      pop_one();

      // Reset in the middle of streaming
      for (int i = 0; i < 3; i++) begin
         drive_push(32'h5000 + 32'(4 * i), 32'h0, 1'b0, 7'h00);
         tick();
      end
      rst_n = 1'b0;
      drive_push(32'h5100, 32'h0, 1'b0, 7'h00);
      settle();
      chk("midrst_fetch_ready", 32'(fetch_ready), 32'd0);
      chk("midrst_dec_valid", 32'(dec_valid), 32'd0);
      tick();
      settle();
      chk("midrst_occ", 32'(occupancy), 32'd0);
      chk("midrst_fetch_ready2", 32'(fetch_ready), 32'd0);
      rst_n = 1'b1;
      drive_push(32'h6000, 32'h0, 1'b0, 7'h00);
      settle();
      chk("resume_fetch_ready", 32'(fetch_ready), 32'd1);
      tick();
      fetch_valid = 1'b0;
      settle();
      chk("resume_pc", dec_pc, 32'h6000);
      chk("resume_occ", 32'(occupancy), 32'd1);
      pop_one();
      settle();
      chk("resume_empty", 32'(dec_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
